// File: rtl/data_mem_pipe.sv
// Pipelined byte-addressable data memory for the MIPS32 load/store unit.
// Valid/ready request side, RD_LAT-deep response pipeline with backpressure.
module data_mem_pipe #(
    parameter int DEPTH  = 1024,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [4*WIDTH-1:0]   req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [4*WIDTH-1:0]   rsp_rdata,
    output logic                 rsp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = 4 * WIDTH;

    logic [WIDTH-1:0] r_mem  [DEPTH];
    logic             r_vld  [RD_LAT];
    logic [DW-1:0]    r_data [RD_LAT];
    logic             r_err  [RD_LAT];

    logic             w_stall;
    logic             w_accept;
    logic             w_err;
    logic             w_misalign;
    logic             w_oor;
    logic [AW-1:0]    w_idx0;
    logic [AW-1:0]    w_idx1;
    logic [AW-1:0]    w_idx2;
    logic [AW-1:0]    w_idx3;
    logic [WIDTH-1:0] w_b0;
    logic [WIDTH-1:0] w_b1;
    logic [WIDTH-1:0] w_b2;
    logic [WIDTH-1:0] w_b3;
    logic [DW-1:0]    w_ldata;
    logic [DW-1:0]    w_rdata;

    assign rsp_valid = r_vld[RD_LAT-1];
    assign rsp_rdata = r_data[RD_LAT-1];
    assign rsp_err   = r_err[RD_LAT-1];

    // A held response freezes the whole pipe, so nothing new may enter.
    assign w_stall   = rsp_valid && !rsp_ready;
    assign req_ready = !w_stall;
    assign w_accept  = req_valid && req_ready;

    assign w_misalign = ((req_size == 2'b01) && req_addr[0]) ||
                        ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_oor      = (req_addr >> AW) != '0;
    assign w_err      = (req_size == 2'b11) || w_misalign || w_oor;

    assign w_idx0 = req_addr[AW-1:0];
    assign w_idx1 = w_idx0 + AW'(1);
    assign w_idx2 = w_idx0 + AW'(2);
    assign w_idx3 = w_idx0 + AW'(3);
    assign w_b0   = r_mem[w_idx0];
    assign w_b1   = r_mem[w_idx1];
    assign w_b2   = r_mem[w_idx2];
    assign w_b3   = r_mem[w_idx3];

    always_comb begin
        w_ldata = '0;
        case (req_size)
            2'b00:   w_ldata = req_unsigned ? {{(DW-WIDTH){1'b0}}, w_b0}
                                            : {{(DW-WIDTH){w_b0[WIDTH-1]}}, w_b0};
            2'b01:   w_ldata = req_unsigned ? {{(DW-2*WIDTH){1'b0}}, w_b1, w_b0}
                                            : {{(DW-2*WIDTH){w_b1[WIDTH-1]}}, w_b1, w_b0};
            2'b10:   w_ldata = {w_b3, w_b2, w_b1, w_b0};
            default: w_ldata = '0;
        endcase
    end

    assign w_rdata = (req_we || w_err) ? '0 : w_ldata;

    // Aligned accesses never wrap, so the upper byte indices are safe to use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_accept && req_we && !w_err) begin
            r_mem[w_idx0] <= req_wdata[WIDTH-1:0];
            if (req_size != 2'b00) begin
                r_mem[w_idx1] <= req_wdata[2*WIDTH-1:WIDTH];
            end
            if (req_size == 2'b10) begin
                r_mem[w_idx2] <= req_wdata[3*WIDTH-1:2*WIDTH];
                r_mem[w_idx3] <= req_wdata[4*WIDTH-1:3*WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_vld[i]  <= 1'b0;
                r_data[i] <= '0;
                r_err[i]  <= 1'b0;
            end
        end else if (!w_stall) begin
            r_vld[0]  <= w_accept;
            r_data[0] <= w_accept ? w_rdata : '0;
            r_err[0]  <= w_accept && w_err;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_data[i] <= r_data[i-1];
                r_err[i]  <= r_err[i-1];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_pipe.sv
// Directed bench for data_mem_pipe: one instance at RD_LAT=1, one at RD_LAT=3.
module tb_data_mem_pipe;

    logic        clk;
    int          vecCount;
    int          missCount;

    logic        aRstN, aReqValid, aReqReady, aReqWe, aReqUns;
    logic [1:0]  aReqSize;
    logic [31:0] aReqAddr, aReqWdata, aRspRdata;
    logic        aRspValid, aRspReady, aRspErr;

    logic        bRstN, bReqValid, bReqReady, bReqWe, bReqUns;
    logic [1:0]  bReqSize;
    logic [31:0] bReqAddr, bReqWdata, bRspRdata;
    logic        bRspValid, bRspReady, bRspErr;

    logic [1:0]  stSize [5];
    logic        stUns  [5];
    logic [31:0] stAddr [5];
    logic [31:0] stExp  [5];

    data_mem_pipe #(.DEPTH(1024), .WIDTH(8), .ADDR_W(32), .RD_LAT(1)) dutA (
        .clk(clk), .rst_n(aRstN), .req_valid(aReqValid), .req_ready(aReqReady),
        .req_we(aReqWe), .req_size(aReqSize), .req_unsigned(aReqUns),
        .req_addr(aReqAddr), .req_wdata(aReqWdata), .rsp_valid(aRspValid),
        .rsp_ready(aRspReady), .rsp_rdata(aRspRdata), .rsp_err(aRspErr)
    );

    data_mem_pipe #(.DEPTH(1024), .WIDTH(8), .ADDR_W(32), .RD_LAT(3)) dutB (
        .clk(clk), .rst_n(bRstN), .req_valid(bReqValid), .req_ready(bReqReady),
        .req_we(bReqWe), .req_size(bReqSize), .req_unsigned(bReqUns),
        .req_addr(bReqAddr), .req_wdata(bReqWdata), .rsp_valid(bRspValid),
        .rsp_ready(bRspReady), .rsp_rdata(bRspRdata), .rsp_err(bRspErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // RD_LAT=1: response must be visible right after the acceptance edge.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expData, input logic expErr, input string tag);
        aReqValid = 1'b1;
        aReqWe    = we;
        aReqSize  = size;
        aReqUns   = uns;
        aReqAddr  = addr;
        aReqWdata = wdata;
        @(posedge clk); #1;
        aReqValid = 1'b0;
        checkOutput({tag, "_v"}, {31'd0, aRspValid}, 32'd1);
        checkOutput({tag, "_d"}, aRspRdata, expData);
        checkOutput({tag, "_e"}, {31'd0, aRspErr}, {31'd0, expErr});
    endtask

    // RD_LAT=3: response absent one edge after acceptance, present two edges after.
    task automatic applyStimulusB(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] expData, input string tag);
        bReqValid = 1'b1;
        bReqWe    = we;
        bReqSize  = size;
        bReqUns   = uns;
        bReqAddr  = addr;
        bReqWdata = wdata;
        @(posedge clk); #1;
        bReqValid = 1'b0;
        @(posedge clk); #1;
        checkOutput({tag, "_early"}, {31'd0, bRspValid}, 32'd0);
        @(posedge clk); #1;
        checkOutput({tag, "_v"}, {31'd0, bRspValid}, 32'd1);
        checkOutput({tag, "_d"}, bRspRdata, expData);
        checkOutput({tag, "_e"}, {31'd0, bRspErr}, 32'd0);
    endtask

    initial begin
        int tx;
        int rx;
        int hold;
        bit seen;

        vecCount  = 0;
        missCount = 0;
        aRstN = 1'b0; aReqValid = 1'b0; aReqWe = 1'b0; aReqSize = 2'b00; aReqUns = 1'b0;
        aReqAddr = '0; aReqWdata = '0; aRspReady = 1'b1;
        bRstN = 1'b0; bReqValid = 1'b0; bReqWe = 1'b0; bReqSize = 2'b00; bReqUns = 1'b0;
        bReqAddr = '0; bReqWdata = '0; bRspReady = 1'b1;

        #12;
        checkOutput("rst_valid", {31'd0, aRspValid}, 32'd0);
        checkOutput("rst_rdata", aRspRdata, 32'd0);
        checkOutput("rst_err", {31'd0, aRspErr}, 32'd0);
        aRstN = 1'b1;
        bRstN = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_ready", {31'd0, aReqReady}, 32'd1);

        applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "sw10");
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, "lb13");
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h000000DE, 1'b0, "lbu13");
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, "lh12");
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, "lhu10");
        applyStimulus(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw10");

        applyStimulus(1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFFFFFF, 32'h0, 1'b1, "sh11_mis");
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, "lw12_mis");
        applyStimulus(1'b1, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, "size11");
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h410, 32'h12345678, 32'h0, 1'b1, "sw410_oor");
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw10_intact");

        applyStimulus(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, "lw400_oor");
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h3FF, 32'h80, 32'h0, 1'b0, "sb3ff");
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h3FF, 32'h0, 32'hFFFFFF80, 1'b0, "lb3ff");

        applyStimulus(1'b1, 2'b00, 1'b0, 32'h20, 32'h5A, 32'h0, 1'b0, "sb20");
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 32'h0000005A, 1'b0, "lbu20_raw");

        @(posedge clk); #1;
        aRspReady = 1'b0;
        #1;
        checkOutput("idle_novalid", {31'd0, aRspValid}, 32'd0);
        checkOutput("idle_ready", {31'd0, aReqReady}, 32'd1);
        aRspReady = 1'b1;

        applyStimulusB(1'b1, 2'b10, 1'b0, 32'h0, 32'h11223344, 32'h0, "b_sw0");
        applyStimulusB(1'b1, 2'b10, 1'b0, 32'h4, 32'h55667788, 32'h0, "b_sw4");
        applyStimulusB(1'b1, 2'b10, 1'b0, 32'h8, 32'h99AABBCC, 32'h0, "b_sw8");
        applyStimulusB(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h55667788, "b_lw4");
        @(posedge clk); #1;

        stSize[0] = 2'b10; stUns[0] = 1'b0; stAddr[0] = 32'h0; stExp[0] = 32'h11223344;
        stSize[1] = 2'b10; stUns[1] = 1'b0; stAddr[1] = 32'h4; stExp[1] = 32'h55667788;
        stSize[2] = 2'b10; stUns[2] = 1'b0; stAddr[2] = 32'h8; stExp[2] = 32'h99AABBCC;
        stSize[3] = 2'b00; stUns[3] = 1'b1; stAddr[3] = 32'h1; stExp[3] = 32'h00000033;
        stSize[4] = 2'b00; stUns[4] = 1'b0; stAddr[4] = 32'hB; stExp[4] = 32'hFFFFFF99;
        tx = 0; rx = 0; hold = 0; seen = 1'b0;
        // Hold rsp_ready low for four cycles starting when the first response shows up.
        for (int cyc = 0; cyc < 40 && rx < 5; cyc++) begin
            if (tx < 5) begin
                bReqValid = 1'b1;
                bReqWe    = 1'b0;
                bReqSize  = stSize[tx];
                bReqUns   = stUns[tx];
                bReqAddr  = stAddr[tx];
            end else begin
                bReqValid = 1'b0;
            end
            if (bRspValid && !seen) begin
                seen = 1'b1;
                hold = 4;
            end
            bRspReady = (hold == 0);
            @(negedge clk);
            if (hold > 0) begin
                checkOutput("stall_ready", {31'd0, bReqReady}, 32'd0);
                checkOutput("stall_hold", bRspRdata, stExp[0]);
                hold--;
            end
            if (bRspValid && bRspReady) begin
                checkOutput($sformatf("stream_rsp%0d", rx), bRspRdata, stExp[rx]);
                checkOutput($sformatf("stream_err%0d", rx), {31'd0, bRspErr}, 32'd0);
                rx++;
            end
            if (bReqValid && bReqReady) tx++;
            @(posedge clk); #1;
        end
        bReqValid = 1'b0;
        bRspReady = 1'b1;
        checkOutput("stream_count", rx, 32'd5);
        checkOutput("stream_nodup", {31'd0, bRspValid}, 32'd0);

        bReqValid = 1'b1; bReqWe = 1'b0; bReqSize = 2'b10; bReqUns = 1'b0; bReqAddr = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        bReqValid = 1'b0;
        checkOutput("prerst_valid", {31'd0, bRspValid}, 32'd1);
        #2;
        bRstN = 1'b0;
        #1;
        checkOutput("async_rst_valid", {31'd0, bRspValid}, 32'd0);
        checkOutput("async_rst_rdata", bRspRdata, 32'd0);
        @(negedge clk);
        bRstN = 1'b1;
        @(posedge clk); #1;
        checkOutput("postrst_ready", {31'd0, bReqReady}, 32'd1);
        checkOutput("postrst_valid", {31'd0, bRspValid}, 32'd0);
        applyStimulusB(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h00000000, "b_lw0_cleared");

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
